// File: rtl/traffic_fsm.sv
// Single-approach traffic light: car head and pedestrian head driven by a timed phase cycle.
// Optional build macro WALK_BLINK_EN blinks the walk lamp during pedestrian clearance.
module traffic_fsm #(
  parameter int T_GREEN  = 10,
  parameter int T_LEFT   = 5,
  parameter int T_YELLOW = 3,
  parameter int T_CLEAR  = 4,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_flag,
  output logic [3:0] o_car_traffic,
  output logic [1:0] o_walker_traffic
);

  // state  | meaning
  // IDLE   | waiting for i_start, car red / don't-walk
  // GREEN  | car green for T_GREEN cycles
  // LEFT   | left-turn arrow for T_LEFT cycles
  // YELLOW | car yellow for T_YELLOW cycles
  // RED    | car red for the other road's whole non-red time; walk until the last T_CLEAR cycles
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_LEFT   = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;
  localparam logic [2:0] S_RED    = 3'd4;

  localparam logic [CW-1:0] LD_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] LD_LEFT   = CW'(T_LEFT - 1);
  localparam logic [CW-1:0] LD_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LD_RED    = CW'(T_GREEN + T_LEFT + T_YELLOW - 1);
  localparam logic [CW-1:0] CLR_CNT   = CW'(T_CLEAR);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_tc;

  assign cnt_tc = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each phase loads count-1 on entry and hands over when the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          if (i_flag) begin
            state_d = S_GREEN;
            cnt_d   = LD_GREEN;
          end else begin
            state_d = S_RED;
            cnt_d   = LD_RED;
          end
        end
      end
      S_GREEN: begin
        if (cnt_tc) begin
          state_d = S_LEFT;
          cnt_d   = LD_LEFT;
        end
      end
      S_LEFT: begin
        if (cnt_tc) begin
          state_d = S_YELLOW;
          cnt_d   = LD_YELLOW;
        end
      end
      S_YELLOW: begin
        if (cnt_tc) begin
          state_d = S_RED;
          cnt_d   = LD_RED;
        end
      end
      S_RED: begin
        if (cnt_tc) begin
          state_d = S_GREEN;
          cnt_d   = LD_GREEN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef WALK_BLINK_EN
  // First clearance cycle (counter == T_CLEAR-1) shows walk, then alternates.
  localparam bit CLR_PAR = (((T_CLEAR - 1) % 2) == 1);
  logic blink_on;
  assign blink_on = (cnt_q[0] == CLR_PAR);
`endif

  always_comb begin
    o_car_traffic    = 4'b0001;
    o_walker_traffic = 2'b01;
    case (state_q)
      S_GREEN:  o_car_traffic = 4'b1000;
      S_LEFT:   o_car_traffic = 4'b0100;
      S_YELLOW: o_car_traffic = 4'b0010;
      S_RED: begin
        o_car_traffic = 4'b0001;
        if (cnt_q >= CLR_CNT) begin
          o_walker_traffic = 2'b10;
        end else begin
`ifdef WALK_BLINK_EN
          o_walker_traffic = {blink_on, 1'b0};
`else
          o_walker_traffic = 2'b01;
`endif
        end
      end
      default: begin
        o_car_traffic    = 4'b0001;
        o_walker_traffic = 2'b01;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench for traffic_fsm: a complementary pair (flag 1 / flag 0) checked against a
// cycle-position model, boundary vector table, async-reset sequence and random start/reset traffic.
module tb_traffic_fsm;

  localparam int TG = 10, TL = 5, TY = 3, TC = 4;
  localparam int HALF = TG + TL + TY;
  localparam int PER  = 2 * HALF;

`ifdef WALK_BLINK_EN
  localparam logic [1:0] CLR_EVEN = 2'b10;
  localparam logic [1:0] CLR_ODD  = 2'b00;
`else
  localparam logic [1:0] CLR_EVEN = 2'b01;
  localparam logic [1:0] CLR_ODD  = 2'b01;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_start = 1'b0;
  logic [3:0] car_a, car_b;
  logic [1:0] walk_a, walk_b;

  always #5 clk = ~clk;

  traffic_fsm dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_flag(1'b1),
    .o_car_traffic(car_a), .o_walker_traffic(walk_a)
  );

  traffic_fsm dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_flag(1'b0),
    .o_car_traffic(car_b), .o_walker_traffic(walk_b)
  );

  int checks = 0;
  int failures = 0;

  // Model: whether the pair is running and how many edges since the start edge.
  bit run = 1'b0;
  int t = 0;

  typedef struct {
    int         t;
    logic [3:0] car_a;
    logic [1:0] walk_a;
    logic [3:0] car_b;
    logic [1:0] walk_b;
  } vec_t;

  vec_t tbl[$];

  function automatic int pos(input int tt, input bit flag);
    return (tt + (flag ? 0 : HALF)) % PER;
  endfunction

  function automatic logic [3:0] m_car(input bit r, input int tt, input bit flag);
    int p;
    if (!r) return 4'b0001;
    p = pos(tt, flag);
    if (p < TG) return 4'b1000;
    if (p < TG + TL) return 4'b0100;
    if (p < HALF) return 4'b0010;
    return 4'b0001;
  endfunction

  function automatic logic [1:0] m_walk(input bit r, input int tt, input bit flag);
    int p;
    if (!r) return 2'b01;
    p = pos(tt, flag);
    if (p < HALF) return 2'b01;
    if (p < PER - TC) return 2'b10;
    return (((p - (PER - TC)) % 2) == 0) ? CLR_EVEN : CLR_ODD;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%b expected=%b at %0t", name, t, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_car_a", car_a, m_car(run, t, 1'b1));
    chk("model_walk_a", {2'b00, walk_a}, {2'b00, m_walk(run, t, 1'b1)});
    chk("model_car_b", car_b, m_car(run, t, 1'b0));
    chk("model_walk_b", {2'b00, walk_b}, {2'b00, m_walk(run, t, 1'b0)});
    chk("onehot_car_a", 4'($countones(car_a)), 4'd1);
    chk("onehot_car_b", 4'($countones(car_b)), 4'd1);
`ifndef WALK_BLINK_EN
    chk("onehot_walk_a", 4'($countones(walk_a)), 4'd1);
    chk("onehot_walk_b", 4'($countones(walk_b)), 4'd1);
`endif
    chk("walk_implies_red_a", {3'b000, walk_a[1] & ~car_a[0]}, 4'd0);
    chk("walk_implies_red_b", {3'b000, walk_b[1] & ~car_b[0]}, 4'd0);
    if (run) chk("complement_red", {3'b000, car_a[0] ^ car_b[0]}, 4'd1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      run = 1'b0;
      t = 0;
    end else if (run) begin
      t++;
    end else if (i_start) begin
      run = 1'b1;
      t = 0;
    end
    #1;
    check_model();
  endtask

  task automatic async_reset_now(input string name);
    reset_n = 1'b0;
    run = 1'b0;
    t = 0;
    #1;
    chk({name, "_car_a"}, car_a, 4'b0001);
    chk({name, "_walk_a"}, {2'b00, walk_a}, 4'b0001);
    chk({name, "_car_b"}, car_b, 4'b0001);
    chk({name, "_walk_b"}, {2'b00, walk_b}, 4'b0001);
  endtask

  initial begin
    int green_len;

    tbl.push_back('{0,  4'b1000, 2'b01,    4'b0001, 2'b10});
    tbl.push_back('{9,  4'b1000, 2'b01,    4'b0001, 2'b10});
    tbl.push_back('{10, 4'b0100, 2'b01,    4'b0001, 2'b10});
    tbl.push_back('{13, 4'b0100, 2'b01,    4'b0001, 2'b10});
    tbl.push_back('{14, 4'b0100, 2'b01,    4'b0001, CLR_EVEN});
    tbl.push_back('{15, 4'b0010, 2'b01,    4'b0001, CLR_ODD});
    tbl.push_back('{17, 4'b0010, 2'b01,    4'b0001, CLR_ODD});
    tbl.push_back('{18, 4'b0001, 2'b10,    4'b1000, 2'b01});
    tbl.push_back('{31, 4'b0001, 2'b10,    4'b0100, 2'b01});
    tbl.push_back('{32, 4'b0001, CLR_EVEN, 4'b0100, 2'b01});
    tbl.push_back('{35, 4'b0001, CLR_ODD,  4'b0010, 2'b01});
    tbl.push_back('{36, 4'b1000, 2'b01,    4'b0001, 2'b10});

    // Values during reset, then idle with i_start low.
    #1;
    chk("reset_car_a", car_a, 4'b0001);
    chk("reset_walk_a", {2'b00, walk_a}, 4'b0001);
    chk("reset_car_b", car_b, 4'b0001);
    chk("reset_walk_b", {2'b00, walk_b}, 4'b0001);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Start on one edge; boundary table plus a mid-GREEN i_start wiggle.
    i_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      foreach (tbl[j]) begin
        if (run && tbl[j].t == t) begin
          chk("vec_car_a", car_a, tbl[j].car_a);
          chk("vec_walk_a", {2'b00, walk_a}, {2'b00, tbl[j].walk_a});
          chk("vec_car_b", car_b, tbl[j].car_b);
          chk("vec_walk_b", {2'b00, walk_b}, {2'b00, tbl[j].walk_b});
        end
      end
      if (t == 3) i_start = 1'b0;
      if (t == 5) i_start = 1'b1;
      if (t == 6) i_start = 1'b0;
    end

    // Advance into LEFT of the second period, then reset between edges.
    while (t < PER + TG + 1) step();
    chk("pre_reset_in_left", car_a, 4'b0100);
    #2;
    async_reset_now("midleft_reset");
    step();
    step();
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Restart: full GREEN count again.
    i_start = 1'b1;
    green_len = 0;
    for (int i = 0; i < TG + 2; i++) begin
      step();
      if (car_a == 4'b1000) green_len++;
      i_start = 1'b0;
    end
    chk("restart_green_len", 4'(green_len), 4'(TG));

    // Random start requests with occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      i_start = ($urandom_range(0, 3) == 0);
      step();
      if ($urandom_range(0, 59) == 0) begin
        #1;
        async_reset_now("rand_reset");
        #1;
        reset_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
Name: traffic_fsm

Overview:
- Single-approach traffic-light controller.
- Sequences one car signal head (red / yellow / left-arrow / green) and one pedestrian head (walk / don't-walk) through a fixed timed cycle.
- Two instances with opposite i_flag form a complementary two-road intersection from one shared clock, reset and start.
- i_flag=1 starts on car green (main road). i_flag=0 starts on car red with pedestrians walking (cross road).

Parameters:
- T_GREEN, 10, cycles of car green.
- T_LEFT, 5, cycles of left-turn arrow after green.
- T_YELLOW, 3, cycles of car yellow.
- T_CLEAR, 4, final cycles of RED during which walker shows don't-walk (pedestrian clearance); must be < T_GREEN+T_LEFT+T_YELLOW.
- CW, 8, width of the phase down-counter; must hold T_GREEN+T_LEFT+T_YELLOW-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request, level-sampled.
- i_flag  input  1  phase select: 1 = start at GREEN, 0 = start at RED; static, sampled only when leaving IDLE.
- o_car_traffic  output  4  one-hot car lamps: [3] green, [2] left arrow, [1] yellow, [0] red.
- o_walker_traffic  output  2  one-hot pedestrian lamps: [1] walk, [0] don't-walk.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n). Reset forces state=IDLE and counter=0.
- Outputs are a pure decode of registered state/counter; no combinational path from any input to any output.
- IDLE outputs: car=4'b0001, walker=2'b01. These are also the values during reset.
- States: IDLE, GREEN, LEFT, YELLOW, RED. Encoding is free.
- IDLE exit: the first rising edge with i_start=1 loads the first phase.
  - i_flag=1: GREEN, counter=T_GREEN-1.
  - i_flag=0: RED, counter=T_GREEN+T_LEFT+T_YELLOW-1.
- After leaving IDLE, i_start is ignored. Only reset returns the block to IDLE.
- Each phase lasts exactly its parameter count of cycles. Counter decrements every cycle; at counter==0 the next edge moves to the next phase and loads its count-1.
- Phase order: GREEN -> LEFT -> YELLOW -> RED -> GREEN, repeating forever.
- RED length is T_GREEN+T_LEFT+T_YELLOW (default 18).
- Full period is 2*(T_GREEN+T_LEFT+T_YELLOW) (default 36). Two instances with opposite i_flag started on the same edge are exact complements: one is RED whenever the other is non-RED.
- Car outputs per state: GREEN 4'b1000, LEFT 4'b0100, YELLOW 4'b0010, RED 4'b0001.
- Walker output:
  - 2'b10 (walk) in RED while counter >= T_CLEAR.
  - 2'b01 (don't-walk) in RED while counter < T_CLEAR, and in every other state.
- Invariant: exactly one car bit and exactly one walker bit high at all times. Walk is never high unless car red is high.
- Reset mid-operation: immediately returns to IDLE outputs, independent of clk. After release, the block waits for i_start again.
- Unused state codes recover to IDLE on the next edge.

Optional Feature:
- Macro: WALK_BLINK_EN.
- Defined: during the T_CLEAR clearance cycles of RED, walker[1] toggles every cycle starting high (high when counter is odd relative to T_CLEAR-1), and walker[0] stays 0.
- Not defined: clearance shows a steady 2'b01 as specified above.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset/idle: reset_n=0 for 1 cycle, then 1 with i_start=0 for 5 cycles -> car=4'b0001, walker=2'b01 throughout, both flag values.
- Start flag=1: i_start=1 sampled at edge k -> GREEN for cycles k..k+9, LEFT k+10..k+14, YELLOW k+15..k+17, RED k+18..k+35, GREEN again at k+36. Walker walk k+18..k+31, don't-walk k+32..k+35.
- Start flag=0 alongside flag=1: same edge -> flag=0 car=4'b0001 with walk for 14 cycles then don't-walk for 4, then GREEN at k+18. At every cycle after k exactly one instance is RED.
- i_start toggling after start: pulse i_start low/high mid-GREEN -> sequence timing unchanged.
- Async reset mid-LEFT: drop reset_n between clock edges -> outputs 4'b0001/2'b01 before the next edge. Restart with i_start gives the full GREEN count again.
- One-hot check: over 80 cycles assert popcount(car)==1 and popcount(walker)==1, and walker[1] implies car[0]. With WALK_BLINK_EN, check walker[1] toggles in the 4 clearance cycles.
